// File: rtl/dm_arbiter_if.sv
// rtl/dm_arbiter_if.sv - requester and DM-port signal bundle for dm_arbiter
// slave: arbiter side; master: requesters plus DM array side.
interface dm_arbiter_if;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic [3:0]  m0_byteen;
  logic [31:0] m0_wdata;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m0_err;

  logic        m1_req;
  logic [31:0] m1_addr;
  logic [3:0]  m1_byteen;
  logic [31:0] m1_wdata;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;
  logic        m1_err;

  logic [31:0] mem_addr;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  m0_req, m0_addr, m0_byteen, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err,
    input  m1_req, m1_addr, m1_byteen, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output mem_addr, mem_byteen, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_addr, m0_byteen, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
    output m1_req, m1_addr, m1_byteen, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
    input  mem_addr, mem_byteen, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-port data-memory arbiter with registered responses
// DMARB_RR_EN defined: round-robin; undefined: fixed M0 priority with M1 anti-starvation.
module dm_arbiter #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned STARVE_MAX  = 4,
  parameter int unsigned CNT_W       = 3
) (
  input  logic         clk,
  input  logic         reset,
  dm_arbiter_if.slave  bus
);

  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

  logic        gnt0;
  logic        gnt1;
  logic [31:0] win_addr;
  logic [3:0]  win_byteen;
  logic [31:0] win_wdata;
  logic        win_in_range;

  logic        m0_rvalid_q, m0_rvalid_d;
  logic        m0_err_q,    m0_err_d;
  logic [31:0] m0_rdata_q,  m0_rdata_d;
  logic        m1_rvalid_q, m1_rvalid_d;
  logic        m1_err_q,    m1_err_d;
  logic [31:0] m1_rdata_q,  m1_rdata_d;

`ifdef DMARB_RR_EN
  // rr_ptr: 0 favours M0 on a tie, 1 favours M1.
  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    rr_ptr_d = rr_ptr_q;
    if (reset) begin
      if (bus.m0_req && bus.m1_req) begin
        gnt0 = ~rr_ptr_q;
        gnt1 = rr_ptr_q;
      end else begin
        gnt0 = bus.m0_req;
        gnt1 = bus.m1_req;
      end
      if (gnt0) begin
        rr_ptr_d = 1'b1;
      end else if (gnt1) begin
        rr_ptr_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             starve_hit;

  always_comb begin
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    starve_hit   = (starve_cnt_q == STARVE_LIM);
    starve_cnt_d = starve_cnt_q;
    if (reset) begin
      gnt1 = bus.m1_req && (!bus.m0_req || starve_hit);
      gnt0 = bus.m0_req && !gnt1;
      if (gnt1) begin
        starve_cnt_d = '0;
      end else if (bus.m1_req && !starve_hit) begin
        starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`endif

  // Winner payload mux; an idle cycle presents address 0 with no lanes.
  always_comb begin
    win_addr   = 32'h0;
    win_byteen = 4'h0;
    win_wdata  = 32'h0;
    if (gnt1) begin
      win_addr   = bus.m1_addr;
      win_byteen = bus.m1_byteen;
      win_wdata  = bus.m1_wdata;
    end else if (gnt0) begin
      win_addr   = bus.m0_addr;
      win_byteen = bus.m0_byteen;
      win_wdata  = bus.m0_wdata;
    end
    win_in_range = (win_addr[31:2] < DEPTH_LIM);
  end

  assign bus.mem_addr   = win_addr & 32'hFFFF_FFFC;
  assign bus.mem_byteen = win_in_range ? win_byteen : 4'h0;
  assign bus.mem_wdata  = win_wdata;

  // Reads capture the array; out-of-range returns zero; in-range writes keep the old rdata.
  always_comb begin
    m0_rvalid_d = gnt0;
    m0_err_d    = gnt0 && !win_in_range;
    m0_rdata_d  = m0_rdata_q;
    if (gnt0) begin
      if (!win_in_range) begin
        m0_rdata_d = 32'h0;
      end else if (win_byteen == 4'h0) begin
        m0_rdata_d = bus.mem_rdata;
      end
    end

    m1_rvalid_d = gnt1;
    m1_err_d    = gnt1 && !win_in_range;
    m1_rdata_d  = m1_rdata_q;
    if (gnt1) begin
      if (!win_in_range) begin
        m1_rdata_d = 32'h0;
      end else if (win_byteen == 4'h0) begin
        m1_rdata_d = bus.mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m0_rvalid_q <= 1'b0;
      m0_err_q    <= 1'b0;
      m0_rdata_q  <= 32'h0;
      m1_rvalid_q <= 1'b0;
      m1_err_q    <= 1'b0;
      m1_rdata_q  <= 32'h0;
    end else begin
      m0_rvalid_q <= m0_rvalid_d;
      m0_err_q    <= m0_err_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rvalid_q <= m1_rvalid_d;
      m1_err_q    <= m1_err_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign bus.m0_gnt    = gnt0;
  assign bus.m0_rvalid = m0_rvalid_q;
  assign bus.m0_err    = m0_err_q;
  assign bus.m0_rdata  = m0_rdata_q;
  assign bus.m1_gnt    = gnt1;
  assign bus.m1_rvalid = m1_rvalid_q;
  assign bus.m1_err    = m1_err_q;
  assign bus.m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - scoreboard bench for dm_arbiter with a behavioural DM and arbitration model
// Honours DMARB_RR_EN to select the expected arbitration policy.
module tb_dm_arbiter;
  localparam int DEPTH  = 4096;
  localparam int STARVE = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dm_arbiter_if bus ();

  dm_arbiter #(.DEPTH_WORDS(DEPTH), .STARVE_MAX(STARVE), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] v;
    v = i;
    if (i == 2) return 32'h1122_3344;
    if (i == 4) return 32'hDEAD_BEEF;
    return {v[15:0] ^ 16'h5A5A, ~v[15:0]};
  endfunction

  // Data memory array: combinational read, byte-lane write at the clock edge.
  logic [31:0] dm [0:DEPTH-1];
  logic dm_loaded = 1'b0;
  int bad_writes = 0;

  assign bus.mem_rdata = (bus.mem_addr[31:2] < 30'(DEPTH)) ? dm[bus.mem_addr[13:2]] : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!dm_loaded) begin
      for (int i = 0; i < DEPTH; i++) dm[i] <= init_word(i);
      dm_loaded <= 1'b1;
    end else if (bus.mem_byteen != 4'h0) begin
      if (bus.mem_addr[31:2] >= 30'(DEPTH)) begin
        bad_writes <= bad_writes + 1;
      end else begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_byteen[b]) dm[bus.mem_addr[13:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
    end
  end

  // Reference model state
  typedef struct {
    int          cyc;
    bit          err;
    bit          rd;
    logic [31:0] rdata;
  } exp_t;

  logic [31:0] ref_mem [0:DEPTH-1];
  bit   ref_loaded = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   m1_losses = 0;
  int   last_w = 1;
  bit   seen_g0 = 0;
  bit   seen_g1 = 0;

  task automatic check_resp(input int p, input bit rv, input bit er, input logic [31:0] rd);
    exp_t e;
    bit have;
    have = 0;
    if (p == 0) begin
      if (q0.size() > 0 && q0[0].cyc == cyc - 1) begin e = q0.pop_front(); have = 1; end
    end else begin
      if (q1.size() > 0 && q1[0].cyc == cyc - 1) begin e = q1.pop_front(); have = 1; end
    end
    check($sformatf("m%0d_rvalid", p), 32'(rv), 32'(have));
    if (have && rv) begin
      check($sformatf("m%0d_err", p), 32'(er), 32'(e.err));
      if (e.rd || e.err) check($sformatf("m%0d_rdata", p), rd, e.rdata);
    end else if (!rv) begin
      check($sformatf("m%0d_err_idle", p), 32'(er), 32'h0);
    end
  endtask

  // Monitor + model: decides the winner from the request pattern, checks the DM port
  // and queues the response expected one cycle later.
  always @(negedge clk) begin
    int w;
    logic [31:0] a, wd;
    logic [3:0] be;
    bit inr;
    exp_t e;
    if (!ref_loaded) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
      ref_loaded = 1;
    end
    if (!reset) begin
      q0.delete();
      q1.delete();
      m1_losses = 0;
      last_w = 1;
      check("rst_m0_gnt", 32'(bus.m0_gnt), 32'h0);
      check("rst_m1_gnt", 32'(bus.m1_gnt), 32'h0);
      check("rst_m0_rvalid", 32'(bus.m0_rvalid), 32'h0);
      check("rst_m1_rvalid", 32'(bus.m1_rvalid), 32'h0);
      check("rst_m0_err", 32'(bus.m0_err), 32'h0);
      check("rst_m1_err", 32'(bus.m1_err), 32'h0);
      check("rst_m0_rdata", bus.m0_rdata, 32'h0);
      check("rst_m1_rdata", bus.m1_rdata, 32'h0);
      check("rst_mem_byteen", 32'(bus.mem_byteen), 32'h0);
    end else begin
      check_resp(0, bus.m0_rvalid, bus.m0_err, bus.m0_rdata);
      check_resp(1, bus.m1_rvalid, bus.m1_err, bus.m1_rdata);

      if (bus.m0_req && bus.m1_req) begin
`ifdef DMARB_RR_EN
        w = 1 - last_w;
`else
        w = (m1_losses >= STARVE) ? 1 : 0;
`endif
      end else if (bus.m0_req) w = 0;
      else if (bus.m1_req) w = 1;
      else w = -1;

      check("m0_gnt", 32'(bus.m0_gnt), 32'(w == 0));
      check("m1_gnt", 32'(bus.m1_gnt), 32'(w == 1));

      a  = (w == 1) ? bus.m1_addr : (w == 0) ? bus.m0_addr : 32'h0;
      be = (w == 1) ? bus.m1_byteen : (w == 0) ? bus.m0_byteen : 4'h0;
      wd = (w == 1) ? bus.m1_wdata : bus.m0_wdata;
      inr = (a[31:2] < 30'(DEPTH));

      check("mem_addr", bus.mem_addr, (w < 0) ? 32'h0 : {a[31:2], 2'b00});
      check("mem_byteen", 32'(bus.mem_byteen), (w >= 0 && inr) ? 32'(be) : 32'h0);
      if (w >= 0 && inr && be != 4'h0) check("mem_wdata", bus.mem_wdata, wd);

      if (w >= 0) begin
        e.cyc   = cyc;
        e.err   = !inr;
        e.rd    = (be == 4'h0);
        e.rdata = inr ? ref_mem[a[13:2]] : 32'h0;
        if (w == 0) q0.push_back(e); else q1.push_back(e);
        if (inr)
          for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[a[13:2]][8*b +: 8] = wd[8*b +: 8];
        last_w = w;
      end
      if (w == 1) m1_losses = 0;
      else if (bus.m1_req) m1_losses++;
    end
    seen_g0 = bus.m0_gnt;
    seen_g1 = bus.m1_gnt;
  end

  task automatic set_m0(input bit r, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    bus.m0_req = r; bus.m0_addr = a; bus.m0_byteen = be; bus.m0_wdata = wd;
  endtask

  task automatic set_m1(input bit r, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    bus.m1_req = r; bus.m1_addr = a; bus.m1_byteen = be; bus.m1_wdata = wd;
  endtask

  task automatic rand_payload(output logic [31:0] a, output logic [3:0] be, output logic [31:0] wd);
    int sel;
    logic [29:0] word;
    sel = $urandom_range(0, 9);
    if (sel == 0) word = 30'(4094 + $urandom_range(0, 3));
    else if (sel == 1) word = 30'($urandom) | 30'h2000_0000;
    else word = 30'($urandom_range(0, 15));
    a  = {word, 2'($urandom)};
    be = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
    wd = $urandom;
  endtask

  initial begin
    logic [31:0] a, wd;
    logic [3:0] be;
    logic [9:0] pat, pat_exp;
    int mism;
    set_m0(0, 32'h0, 4'h0, 32'h0);
    set_m1(0, 32'h0, 4'h0, 32'h0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // T1 lone read of word 4
    @(posedge clk); #1 set_m0(1, 32'h0000_0010, 4'h0, 32'h0);
    @(negedge clk); check("t1_m0_gnt", 32'(bus.m0_gnt), 32'h1);
    @(posedge clk); #1 set_m0(0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    check("t1_m0_rvalid", 32'(bus.m0_rvalid), 32'h1);
    check("t1_m0_rdata", bus.m0_rdata, 32'hDEAD_BEEF);

    // T2 single-lane write by M1
    @(posedge clk); #1 set_m1(1, 32'h0000_0008, 4'b0100, 32'h00AB_0000);
    @(posedge clk); #1 set_m1(0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    check("t2_m1_rvalid", 32'(bus.m1_rvalid), 32'h1);
    check("t2_m1_err", 32'(bus.m1_err), 32'h0);
    check("t2_dm_word2", dm[2], 32'h11AB_3344);

    // T3 out-of-range write
    @(posedge clk); #1 set_m0(1, 32'h0000_4000, 4'hF, 32'hFFFF_FFFF);
    @(negedge clk); check("t3_mem_byteen", 32'(bus.mem_byteen), 32'h0);
    @(posedge clk); #1 set_m0(0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    check("t3_m0_rvalid", 32'(bus.m0_rvalid), 32'h1);
    check("t3_m0_err", 32'(bus.m0_err), 32'h1);
    check("t3_m0_rdata", bus.m0_rdata, 32'h0);

    // Random traffic; requesters hold payload until granted, occasionally withdraw.
    repeat (800) begin
      @(posedge clk); #1;
      if (!bus.m0_req || seen_g0) begin
        rand_payload(a, be, wd);
        set_m0($urandom_range(0, 99) < 60, a, be, wd);
      end else if ($urandom_range(0, 15) == 0) bus.m0_req = 1'b0;
      if (!bus.m1_req || seen_g1) begin
        rand_payload(a, be, wd);
        set_m1($urandom_range(0, 99) < 60, a, be, wd);
      end else if ($urandom_range(0, 15) == 0) bus.m1_req = 1'b0;
    end

    // T6 reset in the cycle after an M0 read grant
    @(posedge clk); #1 set_m0(0, 32'h0, 4'h0, 32'h0); set_m1(0, 32'h0, 4'h0, 32'h0);
    @(posedge clk); #1 set_m0(1, 32'h0000_0014, 4'h0, 32'h0);
    @(negedge clk); check("t6_m0_gnt", 32'(bus.m0_gnt), 32'h1);
    @(posedge clk); #1 set_m0(0, 32'h0, 4'h0, 32'h0); reset = 1'b0;
    #1 check("t6_rvalid_drop", 32'(bus.m0_rvalid), 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    rand_payload(a, be, wd); set_m0(1, a, be, wd);
    rand_payload(a, be, wd); set_m1(1, a, be, wd);
    @(negedge clk); check("t6_first_tie_m0", 32'(bus.m0_gnt), 32'h1);
    pat[0] = bus.m1_gnt;

    // T4/T5 continuous contention from reset
    for (int i = 1; i < 10; i++) begin
      @(posedge clk); #1;
      if (seen_g0) begin rand_payload(a, be, wd); set_m0(1, a, be, wd); end
      if (seen_g1) begin rand_payload(a, be, wd); set_m1(1, a, be, wd); end
      @(negedge clk);
      pat[i] = bus.m1_gnt;
    end
`ifdef DMARB_RR_EN
    pat_exp = 10'b10_1010_1010;
`else
    pat_exp = 10'b10_0001_0000;
`endif
    check("t4_grant_pattern", 32'(pat), 32'(pat_exp));

    @(posedge clk); #1 set_m0(0, 32'h0, 4'h0, 32'h0);
    rand_payload(a, be, wd); set_m1(1, a, be, wd);
    @(negedge clk); check("t5_lone_m1_gnt", 32'(bus.m1_gnt), 32'h1);
    @(posedge clk); #1 set_m1(0, 32'h0, 4'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);

    mism = 0;
    for (int i = 0; i < DEPTH; i++) if (dm[i] !== ref_mem[i]) mism++;
    check("dm_contents_mismatches", 32'(mism), 32'h0);
    check("out_of_range_writes", 32'(bad_writes), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
